// File: rtl/permute_round_sched.sv
// Round scheduler driving the combinational 1024-bit lane permutation.
// Optional feed-forward of the input block: define PERMUTE_ROUND_SCHED_FEEDFORWARD_EN.

module permute (
    input  logic [1023:0] din,
    output logic [1023:0] dout
);
    // Source lane for out lane k sits in nibble k (out lane 0 in the low nibble).
    localparam logic [63:0] SRC_MAP = 64'hF6D2_94B0_583C_1A7E;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            localparam int SRC = int'(SRC_MAP[gi*4 +: 4]);
            assign dout[gi*64 +: 64] = din[SRC*64 +: 64];
        end
    endgenerate
endmodule

module permute_round_sched #(
    parameter int ROUNDS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1023:0] out_data,
    output logic          busy,
    output logic [7:0]    round_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [1023:0] data_reg, data_next;
    logic [7:0]    round_reg, round_next;
    logic [1023:0] rc_vec;
    logic [1023:0] perm_out;
    logic          last_round;

    // Round constant only touches the low byte of lane 0.
    assign rc_vec     = {1016'd0, round_reg + 8'd1};
    assign last_round = (round_reg == 8'(ROUNDS - 1));

    permute u_permute (
        .din  (data_reg ^ rc_vec),
        .dout (perm_out)
    );

`ifdef PERMUTE_ROUND_SCHED_FEEDFORWARD_EN
    logic [1023:0] saved_reg, saved_next;
    logic [1023:0] final_data;

    assign final_data = perm_out ^ saved_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            saved_reg <= '0;
        end else begin
            saved_reg <= saved_next;
        end
    end

    always_comb begin
        saved_next = saved_reg;
        if (state_reg == IDLE && in_valid) begin
            saved_next = in_data;
        end
    end
`else
    logic [1023:0] final_data;

    assign final_data = perm_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            round_reg <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            round_reg <= round_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        round_next = round_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_next  = in_data;
                    round_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_round) begin
                    data_next  = final_data;
                    round_next = '0;
                    state_next = DONE;
                end else begin
                    data_next  = perm_out;
                    round_next = round_reg + 8'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on the state register alone.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == RUN) || (state_reg == DONE);
    assign round_idx = round_reg;
    assign out_data  = data_reg;
endmodule

// File: tb/tb_permute_round_sched.sv
// Randomized self-checking bench for permute_round_sched (ROUNDS=1 and ROUNDS=8 instances).
module tb_permute_round_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          iv1, ir1, ov1, or1, busy1;
    logic [1023:0] id1, od1;
    logic [7:0]    ri1;
    logic          iv8, ir8, ov8, or8, busy8;
    logic [1023:0] id8, od8;
    logic [7:0]    ri8;

    permute_round_sched #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(busy1), .round_idx(ri1)
    );

    permute_round_sched #(.ROUNDS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(busy8), .round_idx(ri8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        int lane;
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            lane = 0;
            for (int k = 15; k >= 0; k--) begin
                if (got[k*64 +: 64] !== exp[k*64 +: 64]) lane = k;
            end
            $display("FAIL %s: got lane %0d = %h, expected %h", tag, lane,
                     got[lane*64 +: 64], exp[lane*64 +: 64]);
        end
    endtask

    // Reference: rounds over an array of lanes, using the documented out<-in lane map.
    function automatic logic [1023:0] model(input logic [1023:0] x, input int rounds);
        logic [63:0]   ln[16];
        logic [63:0]   nx[16];
        int            src[16] = '{14, 7, 10, 1, 12, 3, 8, 5, 0, 11, 4, 9, 2, 13, 6, 15};
        logic [1023:0] r;
        for (int k = 0; k < 16; k++) ln[k] = x[k*64 +: 64];
        for (int rd = 0; rd < rounds; rd++) begin
            ln[0][7:0] = ln[0][7:0] ^ 8'((rd + 1) % 256);
            for (int k = 0; k < 16; k++) nx[k] = ln[src[k]];
            for (int k = 0; k < 16; k++) ln[k] = nx[k];
        end
`ifdef PERMUTE_ROUND_SCHED_FEEDFORWARD_EN
        for (int k = 0; k < 16; k++) ln[k] = ln[k] ^ x[k*64 +: 64];
`endif
        for (int k = 0; k < 16; k++) r[k*64 +: 64] = ln[k];
        return r;
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Accept a block on dut8 (caller ensures IDLE), then count cycles to out_valid.
    task automatic send8(input logic [1023:0] d, output int lat);
        iv8 = 1'b1;
        id8 = d;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        id8 = rand1024();
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 1024'(ir8), 1024'(1));
        check({tag, "_out_valid"}, 1024'(ov8), 1024'(0));
        check({tag, "_busy"}, 1024'(busy8), 1024'(0));
        check({tag, "_out_data"}, od8, '0);
        check({tag, "_round_idx"}, 1024'(ri8), 1024'(0));
    endtask

    logic [1023:0] d, exp, ones15;
    logic [1023:0] q[$];
    int lat, cyc, last, sent, got;

    initial begin
        rst_n = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; id1 = '0;
        iv8 = 1'b0; or8 = 1'b0; id8 = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_low");
        check("rst_low_dut1_ready", 1024'(ir1), 1024'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // ROUNDS=1, zero block: lane 0 constant lands in out lane 8.
        iv1 = 1'b1; id1 = '0; or1 = 1'b1;
        @(negedge clk);
        check("r1_ov_after_accept", 1024'(ov1), 1024'(0));
        check("r1_busy_run", 1024'(busy1), 1024'(1));
        iv1 = 1'b0;
        @(negedge clk);
        check("r1_ov_done", 1024'(ov1), 1024'(1));
        exp = '0; exp[512] = 1'b1;
        check("r1_zero_data", od1, exp);
        @(negedge clk);
        check("r1_ov_cleared", 1024'(ov1), 1024'(0));
        check("r1_ready_back", 1024'(ir1), 1024'(1));

        // Lane 15 all-ones: distinguishes feed-forward from raw build.
        ones15 = '0; ones15[1023:960] = '1;
        iv1 = 1'b1; id1 = ones15; or1 = 1'b0;
        @(negedge clk);
        iv1 = 1'b0;
        @(negedge clk);
        exp = '0; exp[512] = 1'b1;
`ifndef PERMUTE_ROUND_SCHED_FEEDFORWARD_EN
        exp[1023:960] = '1;
`endif
        check("r1_lane15_const", od1, exp);
        check("r1_lane15_model", od1, model(ones15, 1));
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;

        // ROUNDS=8 random block with downstream stall.
        d = rand1024();
        or8 = 1'b0;
        send8(d, lat);
        check("r8_latency", 1024'(lat), 1024'(8));
        exp = model(d, 8);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_data", i), od8, exp);
            check($sformatf("stall%0d_valid", i), 1024'(ov8), 1024'(1));
            check($sformatf("stall%0d_ready", i), 1024'(ir8), 1024'(0));
            @(negedge clk);
        end
        or8 = 1'b1;
        @(negedge clk);
        check("stall_release_ready", 1024'(ir8), 1024'(1));
        check("stall_release_valid", 1024'(ov8), 1024'(0));
        or8 = 1'b0;

        // in_valid held with changing data during RUN; round_idx walk.
        d = rand1024();
        iv8 = 1'b1; id8 = d;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check($sformatf("walk%0d_round_idx", j), 1024'(ri8), 1024'(j));
            check($sformatf("walk%0d_busy", j), 1024'(busy8), 1024'(1));
            id8 = rand1024();
        end
        @(negedge clk);
        check("walk_done_valid", 1024'(ov8), 1024'(1));
        check("walk_done_round_idx", 1024'(ri8), 1024'(0));
        check("walk_done_busy", 1024'(busy8), 1024'(1));
        check("walk_data", od8, model(d, 8));
        iv8 = 1'b0; or8 = 1'b1;
        @(negedge clk);
        check("walk_idle_busy", 1024'(busy8), 1024'(0));
        check("walk_idle_ready", 1024'(ir8), 1024'(1));
        or8 = 1'b0;

        // Reset in the middle of RUN.
        d = rand1024();
        iv8 = 1'b1; id8 = d;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        cyc = 0;
        while (ri8 != 8'd4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("midrun_reached_idx4", 1024'(ri8), 1024'(4));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_hold%0d_valid", i), 1024'(ov8), 1024'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");
        d = rand1024();
        send8(d, lat);
        check("post_rst_latency", 1024'(lat), 1024'(8));
        check("post_rst_data", od8, model(d, 8));
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;

        // Back-to-back blocks with out_ready held: one accept per ROUNDS+2 cycles.
        q = {};
        cyc = 0; last = -1; sent = 0; got = 0;
        or8 = 1'b1;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            id8 = rand1024();
            iv8 = (sent < 4);
            if (ov8) begin
                check($sformatf("tput%0d_data", got), od8, q.pop_front());
                got++;
            end
            if (ir8 && iv8) begin
                if (last >= 0) check($sformatf("tput%0d_gap", sent), 1024'(cyc - last), 1024'(10));
                last = cyc;
                q.push_back(model(id8, 8));
                sent++;
            end
        end
        check("tput_blocks_out", 1024'(got), 1024'(4));
        iv8 = 1'b0; or8 = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
